// File: rtl/bit_destuffer_if.sv
// Bit-level link between the frame controller and the CAN bit destuffer.
// master = frame controller side, slave = destuffer.
interface bit_destuffer_if;
   logic       samplePoint;
   logic       canRX;
   logic       BS_onoff;
   logic       CRCtime;
   logic       EDL;
   logic       isError;
   logic       isStuff;
   logic       stuffError;
   logic [2:0] stuffCount;
   logic       stuffParity;
   logic       fixedMode;

   modport master (
      output samplePoint, canRX, BS_onoff, CRCtime, EDL, isError,
      input  isStuff, stuffError, stuffCount, stuffParity, fixedMode
   );

   modport slave (
      input  samplePoint, canRX, BS_onoff, CRCtime, EDL, isError,
      output isStuff, stuffError, stuffCount, stuffParity, fixedMode
   );
endinterface

// File: rtl/bit_destuffer.sv
// CAN / CAN FD receive bit destuffer: dynamic 5-bit-run stuffing, FD fixed
// stuffing in the CRC field, stuff-rule checking and Gray-coded stuff count.
module bit_destuffer (
   input  logic           clk,
   input  logic           rst_n,
   bit_destuffer_if.slave bus
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] DYNAMIC = 2'd1;
   localparam logic [1:0] FIXED   = 2'd2;

   logic [1:0] state;
   logic       lastBit;
   logic [2:0] runLen;
   logic [2:0] fixedCnt;
   logic [2:0] dynCnt;
   logic       stuffPend;
   logic       stuffErrReg;

   logic       fixedEntry;
   logic       fixedDue;
   logic       sameBit;
   logic [2:0] runNext;
   logic [2:0] grayCnt;

   // fixedCnt counts FD data bits 0..4; the value 4 marks the fixed stuff slot.
   assign fixedEntry = (state == DYNAMIC) & bus.CRCtime & bus.EDL & bus.BS_onoff;
   assign fixedDue   = (state == FIXED) & (fixedCnt == 3'd4);
   assign sameBit    = (bus.canRX == lastBit);
   assign runNext    = sameBit ? (runLen + 3'd1) : 3'd1;
   assign grayCnt    = dynCnt ^ (dynCnt >> 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         lastBit     <= 1'b1;
         runLen      <= 3'd1;
         fixedCnt    <= 3'd0;
         dynCnt      <= 3'd0;
         stuffPend   <= 1'b0;
         stuffErrReg <= 1'b0;
      end else if (bus.isError) begin
         state       <= IDLE;
         stuffPend   <= 1'b0;
         fixedCnt    <= 3'd0;
         stuffErrReg <= 1'b0;
      end else begin
         stuffErrReg <= 1'b0;
         if (bus.samplePoint) begin
            if (!bus.BS_onoff) begin
               state     <= IDLE;
               lastBit   <= bus.canRX;
               runLen    <= 3'd1;
               stuffPend <= 1'b0;
               fixedCnt  <= 3'd0;
            end else begin
               case (state)
                  IDLE: begin
                     // The entry bit (normally SOF) opens the first run.
                     state     <= DYNAMIC;
                     dynCnt    <= 3'd0;
                     lastBit   <= bus.canRX;
                     runLen    <= 3'd1;
                     stuffPend <= 1'b0;
                  end
                  DYNAMIC: begin
                     lastBit <= bus.canRX;
                     if (fixedEntry) begin
                        stuffErrReg <= sameBit;
                        state       <= FIXED;
                        fixedCnt    <= 3'd0;
                        stuffPend   <= 1'b0;
                        runLen      <= 3'd1;
                     end else if (stuffPend) begin
                        stuffErrReg <= sameBit;
                        runLen      <= 3'd1;
                        stuffPend   <= 1'b0;
                        dynCnt      <= dynCnt + 3'd1;
                     end else begin
                        runLen    <= runNext;
                        stuffPend <= (runNext == 3'd5);
                     end
                  end
                  FIXED: begin
                     lastBit <= bus.canRX;
                     if (fixedCnt == 3'd4) begin
                        stuffErrReg <= sameBit;
                        fixedCnt    <= 3'd0;
                     end else begin
                        fixedCnt <= fixedCnt + 3'd1;
                     end
                  end
                  default: state <= IDLE;
               endcase
            end
         end
      end
   end

   assign bus.isStuff     = ((state == DYNAMIC) & stuffPend) | fixedDue | fixedEntry;
   assign bus.stuffError  = stuffErrReg;
   assign bus.stuffCount  = grayCnt;
   assign bus.stuffParity = ^grayCnt;
   assign bus.fixedMode   = (state == FIXED);

endmodule
